// File: rtl/float_pkg.sv
// Shared single-precision field constants and addsub state encoding.
// Also consumed by float_mul.
package float_pkg;

    localparam int EXP_W   = 8;
    localparam int MANT_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ALIGN  = 3'd1;
    localparam logic [2:0] ST_ADD    = 3'd2;
    localparam logic [2:0] ST_NORM   = 3'd3;
    localparam logic [2:0] ST_ROUND  = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        ALIGN  = ST_ALIGN,
        ADD    = ST_ADD,
        NORM   = ST_NORM,
        ROUND  = ST_ROUND,
        FINISH = ST_FINISH
    } state_t;

endpackage

// File: rtl/float_addsub_lzc24.sv
// Combinational 24-bit leading-zero counter; all-zero input yields 24.
module lzc24 (
    input  logic [23:0] val,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (val[i]) count = 5'(23 - i);
        end
    end

endmodule

// File: rtl/float_addsub.sv
// Multi-cycle single-precision adder/subtractor with start/ready handshake.
module float_addsub
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] float_in_1,
    input  logic [31:0] float_in_2,
    output logic [31:0] float_out,
    output logic        ready
);

    localparam logic signed [9:0] EXP_SAT = 10'(EXP_MAX);

    state_t             state;
    logic [31:0]        reg_a;
    logic [31:0]        reg_b;
    logic               res_sign;
    logic               eff_sub;
    logic signed [9:0]  res_exp;
    logic [24:0]        sig_a;
    logic [24:0]        sig_b;
    logic [25:0]        sig;

    logic [EXP_W-1:0]   ea, eb, big_e, small_e, d;
    logic [MANT_W-1:0]  ma, mb, big_m, small_m;
    logic               big_s, small_s, swap;
    logic [24:0]        small_sig, shifted;
    logic [4:0]         lz;
    logic signed [9:0]  norm_exp;

    // Zero exponent means exact zero: mantissa is flushed before compare.
    assign ea = reg_a[30:23];
    assign eb = reg_b[30:23];
    assign ma = (ea == '0) ? '0 : reg_a[22:0];
    assign mb = (eb == '0) ? '0 : reg_b[22:0];

    assign swap    = {eb, mb} > {ea, ma};
    assign big_e   = swap ? eb : ea;
    assign big_m   = swap ? mb : ma;
    assign big_s   = swap ? reg_b[31] : reg_a[31];
    assign small_e = swap ? ea : eb;
    assign small_m = swap ? ma : mb;
    assign small_s = swap ? reg_a[31] : reg_b[31];

    assign d         = big_e - small_e;
    assign small_sig = {small_e != '0, small_m, 1'b0};
    assign shifted   = (d >= 8'd25) ? '0 : (small_sig >> d);

    lzc24 u_lzc (
        .val   (sig[24:1]),
        .count (lz)
    );

    assign norm_exp = res_exp - $signed({5'd0, lz});

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            float_out <= POS_ZERO;
            ready     <= 1'b0;
            reg_a     <= '0;
            reg_b     <= '0;
            res_sign  <= 1'b0;
            eff_sub   <= 1'b0;
            res_exp   <= '0;
            sig_a     <= '0;
            sig_b     <= '0;
            sig       <= '0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        reg_a <= float_in_1;
                        reg_b <= {float_in_2[31] ^ op, float_in_2[30:0]};
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    res_sign <= big_s;
                    eff_sub  <= big_s ^ small_s;
                    res_exp  <= {2'b00, big_e};
                    sig_a    <= {big_e != '0, big_m, 1'b0};
                    sig_b    <= shifted;
                    state    <= ADD;
                end
                ADD: begin
                    sig   <= eff_sub ? ({1'b0, sig_a} - {1'b0, sig_b})
                                     : ({1'b0, sig_a} + {1'b0, sig_b});
                    state <= NORM;
                end
                NORM: begin
                    if (sig == '0) begin
                        res_sign <= 1'b0;
                        res_exp  <= '0;
                    end else if (sig[25]) begin
                        sig     <= sig >> 1;
                        res_exp <= res_exp + 10'sd1;
                    end else if (norm_exp < 10'sd1) begin
                        res_exp <= '0;
                        sig     <= '0;
                    end else begin
                        sig     <= sig << lz;
                        res_exp <= norm_exp;
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    if (sig[0]) begin
                        sig[0] <= 1'b0;
                        if (&sig[23:1]) begin
                            sig[23:1] <= '0;
                            res_exp   <= res_exp + 10'sd1;
                        end else begin
                            sig[23:1] <= sig[23:1] + 23'd1;
                        end
                    end
                    state <= FINISH;
                end
                FINISH: begin
                    if (res_exp >= EXP_SAT)
                        float_out <= {res_sign, POS_INF[30:0]};
                    else
                        float_out <= {res_sign, res_exp[7:0], sig[23:1]};
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_addsub.sv
// Randomised and directed self-checking bench for float_addsub.
module tb_float_addsub;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] float_in_1;
    logic [31:0] float_in_2;
    logic [31:0] float_out;
    logic        ready;

    int n_vec;
    int n_err;

    float_addsub dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .float_in_1 (float_in_1),
        .float_in_2 (float_in_2),
        .float_out  (float_out),
        .ready      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Reference: exact integer arithmetic following the operation's rules.
    function automatic logic [31:0] ref_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic op_i);
        logic   sa, sb, ts;
        int     ea, eb, e, d, te;
        longint fa, fb, tf, sa_v, sb_v, r, m;
        sa = a[31];
        sb = b[31] ^ op_i;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = (ea == 0) ? 0 : longint'(a[22:0]);
        fb = (eb == 0) ? 0 : longint'(b[22:0]);
        if (longint'(eb) * 8388608 + fb > longint'(ea) * 8388608 + fa) begin
            te = ea; ea = eb; eb = te;
            tf = fa; fa = fb; fb = tf;
            ts = sa; sa = sb; sb = ts;
        end
        sa_v = (ea == 0) ? 0 : (8388608 + fa) * 2;
        sb_v = (eb == 0) ? 0 : (8388608 + fb) * 2;
        d = ea - eb;
        sb_v = (d >= 25) ? 0 : (sb_v >> d);
        r = (sa == sb) ? sa_v + sb_v : sa_v - sb_v;
        e = ea;
        if (r == 0) return 32'h0;
        if (r >= 33554432) begin
            r = r >> 1;
            e++;
        end else begin
            while (r < 16777216) begin
                r = r << 1;
                e--;
            end
        end
        if (e < 1) return {sa, 31'b0};
        m = (r >> 1) % 8388608;
        if (r % 2 == 1) begin
            m++;
            if (m == 8388608) begin
                m = 0;
                e++;
            end
        end
        if (e >= 255) return {sa, 8'hFF, 23'b0};
        return {sa, 8'(e), 23'(m)};
    endfunction

    // Transaction-level expectation: busy window, completion cycle, value.
    int          cyc;
    int          m_done;
    logic        m_busy;
    logic        m_ready;
    logic [31:0] m_out;
    logic [31:0] m_val;
    logic        chk_en;

    initial begin
        cyc = 0; m_busy = 0; m_ready = 0; m_out = 0; m_val = 0; m_done = 0;
    end

    always @(posedge clk) begin
        logic was_busy;
        if (rst) begin
            m_busy  = 0;
            m_ready = 0;
            m_out   = 0;
        end else begin
            was_busy = m_busy;
            m_ready  = 0;
            if (m_busy && cyc == m_done) begin
                m_out   = m_val;
                m_ready = 1;
                m_busy  = 0;
            end
            if (!was_busy && start) begin
                m_busy = 1;
                m_done = cyc + 5;
                m_val  = ref_add(float_in_1, float_in_2, op);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'b0, ready}, {31'b0, m_ready});
            check("float_out", float_out, m_out);
        end
    end

    task automatic wait_ready(input int k0, output int k);
        k = k0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
        end while (!ready && k < 20);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", {31'b0, m_busy}, 32'h0);
    endtask

    task automatic run_dir(input string name, input logic [31:0] a,
                           input logic [31:0] b, input logic o,
                           input logic [31:0] expv);
        int k;
        check({name, "_model"}, ref_add(a, b, o), expv);
        wait_idle();
        float_in_1 = a;
        float_in_2 = b;
        op         = o;
        start      = 1'b1;
        wait_ready(0, k);
        float_in_1 = $urandom;
        float_in_2 = $urandom;
        check({name, "_latency"}, k, 6);
        check({name, "_out"}, float_out, expv);
        @(posedge clk);
        #1;
        check({name, "_ready_drop"}, {31'b0, ready}, 32'h0);
    endtask

    function automatic logic [31:0] rnd_float(input int base_e);
        int   r, e;
        r = int'($urandom_range(0, 15));
        if (r == 0) e = 0;
        else if (r < 9) e = base_e + int'($urandom_range(0, 6)) - 3;
        else e = int'($urandom_range(1, 254));
        if (r != 0 && e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    initial begin
        int k;
        int be;
        n_vec = 0; n_err = 0; chk_en = 1'b1;
        rst = 1'b1; start = 1'b0; op = 1'b0;
        float_in_1 = 32'h0; float_in_2 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", float_out, 32'h0);
        check("reset_ready", {31'b0, ready}, 32'h0);
        rst = 1'b0;

        run_dir("corr", 32'h3FC00000, 32'h3F000000, 1'b1, 32'h3F800000);
        run_dir("carry", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        run_dir("cancel", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
        run_dir("shiftout", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000);
        run_dir("guard", 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002);
        run_dir("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
        run_dir("neg", 32'h3F000000, 32'h3FC00000, 1'b1, 32'hBF800000);
        run_dir("zero_op", 32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000);

        // Second start two cycles in must be ignored; a start in the
        // ready cycle must be taken.
        wait_idle();
        float_in_1 = 32'h3FC00000; float_in_2 = 32'h3F000000; op = 1'b1;
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        float_in_1 = 32'h40400000; float_in_2 = 32'h40000000; op = 1'b0;
        start = 1'b1;
        wait_ready(2, k);
        check("ignore_latency", k, 6);
        check("ignore_out", float_out, 32'h3F800000);
        float_in_1 = 32'h3F800000; float_in_2 = 32'h3F800000; op = 1'b0;
        start = 1'b1;
        wait_ready(0, k);
        check("b2b_latency", k, 6);
        check("b2b_out", float_out, 32'h40000000);

        // Reset while the operation sits in NORM.
        wait_idle();
        float_in_1 = 32'h40400000; float_in_2 = 32'h3F800000; op = 1'b0;
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("rst_out", float_out, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("rst_no_ready", {31'b0, ready}, 32'h0);
        end
        run_dir("after_rst", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000);

        for (int i = 0; i < 400; i++) begin
            repeat ($urandom_range(0, 8)) begin
                @(posedge clk); #1;
            end
            be = int'($urandom_range(1, 254));
            float_in_1 = rnd_float(be);
            float_in_2 = rnd_float(be);
            op = 1'($urandom);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (10) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
